alu_rs: RTL

ALU_RS -- requirements
Module: alu_rs

---
 rtl/alu_rs_pkg.sv | 66 ++++++
 rtl/alu_rs_age_select.sv | 32 +++
 rtl/alu_rs.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: types shared by the ALU reservation station.
//   GPR_SIZE / ROB_IDX_SIZE : register and ROB-index widths
//   alu_op_t, nzcv_t         : ALU opcode and flag types
//   rs_opnd_t, rs_entry_t    : reservation-station operand / entry layout
//   capture_opnd()           : operand capture with result-bus bypass
package alu_rs_pkg;

  localparam int GPR_SIZE     = 32;
  localparam int ROB_IDX_SIZE = 5;

  typedef enum logic [2:0] {
    ALU_PLUS  = 3'd0,
    ALU_MINUS = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_LSL   = 3'd5,
    ALU_LSR   = 3'd6,
    ALU_MOV   = 3'd7
  } alu_op_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  typedef struct packed {
    logic                    ready;
    logic [GPR_SIZE-1:0]     val;
    logic [ROB_IDX_SIZE-1:0] tag;
  } rs_opnd_t;

  typedef struct packed {
    logic                    valid;
    alu_op_t                 op;
    logic [ROB_IDX_SIZE-1:0] dst_rob_index;
    logic                    set_nzcv;
    nzcv_t                   nzcv;
    rs_opnd_t                a;
    rs_opnd_t                b;
  } rs_entry_t;

  // A not-ready operand whose producer broadcasts in the same cycle it is
  // dispatched would otherwise miss the broadcast forever.
  function automatic rs_opnd_t capture_opnd(
    input logic                    ready,
    input logic [GPR_SIZE-1:0]     val,
    input logic [ROB_IDX_SIZE-1:0] tag,
    input logic                    cdb_valid,
    input logic [ROB_IDX_SIZE-1:0] cdb_rob_index,
    input logic [GPR_SIZE-1:0]     cdb_value
  );
    rs_opnd_t o;
    o.ready = ready;
    o.val   = val;
    o.tag   = tag;
    if (!ready && cdb_valid && (cdb_rob_index == tag)) begin
      o.ready = 1'b1;
      o.val   = cdb_value;
    end
    return o;
  endfunction

endpackage

// File: rtl/alu_rs_age_select.sv
// rs_age_select: combinational oldest-eligible picker.
//   eligible : per-entry issue-eligible flags
//   age      : per-entry age (larger = older)
//   found    : at least one entry is eligible
//   idx      : eligible entry with greatest age, lowest index on ties
module rs_age_select #(
  parameter int ENTRIES = 4,
  parameter int AGE_W   = 2
) (
  input  logic [ENTRIES-1:0]            eligible,
  input  logic [ENTRIES-1:0][AGE_W-1:0] age,
  output logic                          found,
  output logic [AGE_W-1:0]              idx
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    found    = 1'b0;
    idx      = '0;
    best_age = '0;
    // Strict compare keeps the lower index on equal ages.
    for (int i = 0; i < ENTRIES; i++) begin
      if (eligible[i] && (!found || (age[i] > best_age))) begin
        found    = 1'b1;
        idx      = AGE_W'(i);
        best_age = age[i];
      end
    end
  end

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with result-bus wakeup and
// oldest-first issue.
//   in_clk / in_rst_n           : clock, async active-low reset
//   in_flush                    : synchronous squash of all entries
//   in_disp_* / out_disp_ready  : dispatch handshake and payload
//   in_cdb_*                    : result broadcast (wakeup)
//   in_fu_ready / out_fu_*      : registered issue to the ALU
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_flush,
  input  logic                    in_disp_valid,
  output logic                    out_disp_ready,
  input  alu_op_t                 in_disp_op,
  input  logic [ROB_IDX_SIZE-1:0] in_disp_dst_rob_index,
  input  logic                    in_disp_set_nzcv,
  input  nzcv_t                   in_disp_nzcv,
  input  logic                    in_disp_a_ready,
  input  logic [GPR_SIZE-1:0]     in_disp_a_val,
  input  logic [ROB_IDX_SIZE-1:0] in_disp_a_tag,
  input  logic                    in_disp_b_ready,
  input  logic [GPR_SIZE-1:0]     in_disp_b_val,
  input  logic [ROB_IDX_SIZE-1:0] in_disp_b_tag,
  input  logic                    in_cdb_valid,
  input  logic [ROB_IDX_SIZE-1:0] in_cdb_rob_index,
  input  logic [GPR_SIZE-1:0]     in_cdb_value,
  input  logic                    in_fu_ready,
  output logic                    out_fu_start,
  output alu_op_t                 out_fu_op,
  output logic [GPR_SIZE-1:0]     out_fu_val_a,
  output logic [GPR_SIZE-1:0]     out_fu_val_b,
  output logic [ROB_IDX_SIZE-1:0] out_fu_dst_rob_index,
  output logic                    out_fu_set_nzcv,
  output nzcv_t                   out_fu_nzcv
);

  localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(ENTRIES - 1);

  rs_entry_t                      ent [ENTRIES];
  logic [ENTRIES-1:0][IDX_W-1:0]  age;
  logic [ENTRIES-1:0]             valid_vec;
  logic [ENTRIES-1:0]             elig;
  logic [IDX_W-1:0]               free_idx;
  logic [IDX_W-1:0]               sel_idx;
  logic                           sel_found;
  logic                           disp_fire;
  logic                           issue;
  rs_entry_t                      disp_ent;

  always_comb begin
    valid_vec = '0;
    elig      = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_vec[i] = ent[i].valid;
      elig[i]      = ent[i].valid & ent[i].a.ready & ent[i].b.ready;
    end
  end

  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent[i].valid) free_idx = IDX_W'(i);
    end
  end

  // Credit comes from registered valid bits only, so an entry issuing this
  // cycle does not free a slot until the next one.
  assign out_disp_ready = ~&valid_vec;
  assign disp_fire      = in_disp_valid & out_disp_ready;
  assign issue          = in_fu_ready & sel_found;

  always_comb begin
    disp_ent               = '0;
    disp_ent.valid         = 1'b1;
    disp_ent.op            = in_disp_op;
    disp_ent.dst_rob_index = in_disp_dst_rob_index;
    disp_ent.set_nzcv      = in_disp_set_nzcv;
    disp_ent.nzcv          = in_disp_nzcv;
    disp_ent.a = capture_opnd(in_disp_a_ready, in_disp_a_val, in_disp_a_tag,
                              in_cdb_valid, in_cdb_rob_index, in_cdb_value);
    disp_ent.b = capture_opnd(in_disp_b_ready, in_disp_b_val, in_disp_b_tag,
                              in_cdb_valid, in_cdb_rob_index, in_cdb_value);
  end

  rs_age_select #(
    .ENTRIES (ENTRIES),
    .AGE_W   (IDX_W)
  ) u_age_select (
    .eligible (elig),
    .age      (age),
    .found    (sel_found),
    .idx      (sel_idx)
  );

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ent[i] <= '0;
      age                  <= '0;
      out_fu_start         <= 1'b0;
      out_fu_op            <= ALU_PLUS;
      out_fu_val_a         <= '0;
      out_fu_val_b         <= '0;
      out_fu_dst_rob_index <= '0;
      out_fu_set_nzcv      <= 1'b0;
      out_fu_nzcv          <= '0;
    end else if (in_flush) begin
      for (int i = 0; i < ENTRIES; i++) ent[i].valid <= 1'b0;
      out_fu_start <= 1'b0;
    end else begin
      out_fu_start <= issue;

      for (int i = 0; i < ENTRIES; i++) begin
        if (ent[i].valid && in_cdb_valid) begin
          if (!ent[i].a.ready && (ent[i].a.tag == in_cdb_rob_index)) begin
            ent[i].a.ready <= 1'b1;
            ent[i].a.val   <= in_cdb_value;
          end
          if (!ent[i].b.ready && (ent[i].b.tag == in_cdb_rob_index)) begin
            ent[i].b.ready <= 1'b1;
            ent[i].b.val   <= in_cdb_value;
          end
        end
        if (disp_fire && ent[i].valid && (age[i] != AGE_MAX)) begin
          age[i] <= age[i] + 1'b1;
        end
      end

      if (issue) begin
        ent[sel_idx].valid   <= 1'b0;
        out_fu_op            <= ent[sel_idx].op;
        out_fu_val_a         <= ent[sel_idx].a.val;
        out_fu_val_b         <= ent[sel_idx].b.val;
        out_fu_dst_rob_index <= ent[sel_idx].dst_rob_index;
        out_fu_set_nzcv      <= ent[sel_idx].set_nzcv;
        out_fu_nzcv          <= ent[sel_idx].nzcv;
      end

      // The free slot is never the issuing one, so these writes cannot clash.
      if (disp_fire) begin
        ent[free_idx] <= disp_ent;
        age[free_idx] <= '0;
      end
    end
  end

endmodule
